fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer that owns the program counter and the instruction-memory enable for the five-stage pipeline.
- It replaces a free-running PC with a handshaked fetch: it drives pc and ce to instruction ROM and waits for mem_ack.
- It holds fetched words in a one-entry output register for ID under pipeline stall.
- It applies branch redirects with MIPS delay-slot semantics and exception flushes.

---
 rtl/fetch_ctrl_if.sv | 48 ++++
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: instruction-ROM request/ack plus ID-side slot
// and redirect controls.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              ce;
  logic [ADDR_W-1:0] pc;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    input  stall,
    input  branch_flag,
    input  branch_target,
    input  flush,
    input  flush_pc,
    input  mem_ack,
    input  mem_rdata,
    output ce,
    output pc,
    output inst_valid,
    output inst,
    output inst_pc
  );

  modport slave (
    output stall,
    output branch_flag,
    output branch_target,
    output flush,
    output flush_pc,
    output mem_ack,
    output mem_rdata,
    input  ce,
    input  pc,
    input  inst_valid,
    input  inst,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Handshaked instruction fetch: owns pc/ce, one-entry slot to ID,
// delay-slot branch redirects and exception flushes.
module fetch_ctrl #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    BR_PEND
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              iv_q, iv_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              br_pend, br_pend_d;
  logic [ADDR_W-1:0] br_tgt, br_tgt_d;

  logic              ce;
  logic              slot_free;
  logic              transfer;
  logic              br_take;
  logic [ADDR_W-1:0] pc_seq;

  assign ce        = (state_q != IDLE);
  assign slot_free = ~iv_q | ~bus.stall;
  // a flush discards any same-cycle ack
  assign transfer  = ce & bus.mem_ack
                   & slot_free & ~bus.flush;
  assign br_take   = bus.branch_flag & ~bus.stall;
  assign pc_seq    = pc_q + ADDR_W'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      iv_q    <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
      br_pend <= 1'b0;
      br_tgt  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iv_q    <= iv_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      br_pend <= br_pend_d;
      br_tgt  <= br_tgt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    iv_d      = iv_q;
    inst_d    = inst_q;
    ipc_d     = ipc_q;
    br_pend_d = br_pend;
    br_tgt_d  = br_tgt;

    if (bus.flush) begin
      pc_d      = bus.flush_pc;
      iv_d      = 1'b0;
      br_pend_d = 1'b0;
      state_d   = FETCH;
    end else begin
      if (transfer) begin
        inst_d = bus.mem_rdata;
        ipc_d  = pc_q;
        iv_d   = 1'b1;
      end else if (iv_q && !bus.stall) begin
        iv_d = 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          state_d = FETCH;
        end
        FETCH: begin
          if (br_take) begin
            if (transfer) begin
              pc_d = bus.branch_target;
            end else begin
              br_tgt_d  = bus.branch_target;
              br_pend_d = 1'b1;
              state_d   = BR_PEND;
            end
          end else if (transfer) begin
            pc_d = pc_seq;
          end
        end
        // delay slot cannot branch: branch_flag ignored here
        BR_PEND: begin
          if (transfer) begin
            pc_d      = br_tgt;
            br_pend_d = 1'b0;
            state_d   = FETCH;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.ce         = ce;
  assign bus.pc         = pc_q;
  assign bus.inst_valid = iv_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = ipc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; ROM returns ~pc so every fetched
// word is traceable to its address.
module tb_fetch_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  fetch_ctrl_if #(.ADDR_W(32)) bus ();

  fetch_ctrl #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  assign bus.mem_rdata = ~bus.pc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic ce,
                            input logic [31:0] pc, input logic iv,
                            input logic [31:0] ipc);
    n_cmp++;
    if (bus.ce !== ce) begin
      n_bad++;
      $display("FAIL %s ce got %b want %b", nm, bus.ce, ce);
    end
    n_cmp++;
    if (bus.pc !== pc) begin
      n_bad++;
      $display("FAIL %s pc got %h want %h", nm, bus.pc, pc);
    end
    n_cmp++;
    if (bus.inst_valid !== iv) begin
      n_bad++;
      $display("FAIL %s inst_valid got %b want %b", nm,
               bus.inst_valid, iv);
    end
    n_cmp++;
    if (bus.inst_pc !== ipc) begin
      n_bad++;
      $display("FAIL %s inst_pc got %h want %h", nm, bus.inst_pc, ipc);
    end
    if (iv) begin
      n_cmp++;
      if (bus.inst !== ~ipc) begin
        n_bad++;
        $display("FAIL %s inst got %h want %h", nm, bus.inst, ~ipc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.branch_flag = 1'b0;
    bus.branch_target = '0;
    bus.flush = 1'b0;
    bus.flush_pc = '0;
    bus.mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    n_cmp++;
    if (bus.inst !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_inst got %h want 0", bus.inst);
    end
    #2 rst = 1'b1;
    tick();
    expect_out("idle_exit", 1'b1, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_out("seq", 1'b1, 32'(4 * i), 1'b1, 32'(4 * (i - 1)));
    end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("stall_hold", 1'b1, 32'hC, 1'b1, 32'h8);
    end
    bus.stall = 1'b0;
    tick();
    expect_out("stall_release", 1'b1, 32'h10, 1'b1, 32'hC);
  endtask

  task automatic test_branch_delay();
    tick();
    expect_out("pre_branch", 1'b1, 32'h14, 1'b1, 32'h10);
    bus.branch_flag = 1'b1;
    bus.branch_target = 32'h100;
    tick();
    expect_out("delay_slot", 1'b1, 32'h100, 1'b1, 32'h14);
    bus.branch_flag = 1'b0;
    tick();
    expect_out("branch_tgt", 1'b1, 32'h104, 1'b1, 32'h100);
  endtask

  task automatic test_branch_pending();
    bus.flush = 1'b1;
    bus.flush_pc = 32'h10;
    tick();
    expect_out("redir_0x10", 1'b1, 32'h10, 1'b0, 32'h100);
    bus.flush = 1'b0;
    tick();
    expect_out("fetch_0x10", 1'b1, 32'h14, 1'b1, 32'h10);
    bus.branch_flag = 1'b1;
    bus.branch_target = 32'h200;
    bus.mem_ack = 1'b0;
    tick();
    expect_out("br_pend1", 1'b1, 32'h14, 1'b0, 32'h10);
    bus.branch_target = 32'h300;
    tick();
    expect_out("br_pend2", 1'b1, 32'h14, 1'b0, 32'h10);
    bus.branch_flag = 1'b0;
    bus.mem_ack = 1'b1;
    tick();
    expect_out("br_pend_ack", 1'b1, 32'h200, 1'b1, 32'h14);
    tick();
    expect_out("br_pend_done", 1'b1, 32'h204, 1'b1, 32'h200);
  endtask

  task automatic test_flush();
    bus.branch_flag = 1'b1;
    bus.branch_target = 32'h400;
    bus.mem_ack = 1'b0;
    tick();
    expect_out("fl_brpend", 1'b1, 32'h204, 1'b0, 32'h200);
    bus.branch_flag = 1'b0;
    bus.flush = 1'b1;
    bus.flush_pc = 32'hBFC0_0380;
    bus.stall = 1'b1;
    bus.mem_ack = 1'b1;
    tick();
    expect_out("flush", 1'b1, 32'hBFC0_0380, 1'b0, 32'h200);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    tick();
    expect_out("post_flush1", 1'b1, 32'hBFC0_0384, 1'b1, 32'hBFC0_0380);
    tick();
    expect_out("post_flush2", 1'b1, 32'hBFC0_0388, 1'b1, 32'hBFC0_0384);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    bus.flush_pc = 32'h80;
    tick();
    expect_out("flush_stalled", 1'b1, 32'h80, 1'b0, 32'hBFC0_0384);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic test_wrap();
    bus.flush = 1'b1;
    bus.flush_pc = 32'hFFFF_FFFC;
    tick();
    expect_out("wrap_redir", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hBFC0_0384);
    bus.flush = 1'b0;
    tick();
    expect_out("wrap", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);
    tick();
    expect_out("wrap_next", 1'b1, 32'h4, 1'b1, 32'h0);
  endtask

  task automatic test_async_reset();
    tick();
    expect_out("pre_rst", 1'b1, 32'h8, 1'b1, 32'h4);
    #2 rst = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    tick();
    expect_out("rst_idle_exit", 1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    expect_out("rst_resume", 1'b1, 32'h4, 1'b1, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_delay();
    test_branch_pending();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
